// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and a frequency-to-half-period helper for the clock divider.
//   CLK_IN_HZ    : nominal input clock frequency
//   DEF_CNT_W    : default counter / half-period register width
//   DEF_HALF     : default half-period minus one (10 Hz out of 100 MHz)
//   half_for_hz  : half-period minus one that yields the requested output frequency
package clk_div_pkg;
    localparam int CLK_IN_HZ = 100000000;
    localparam int DEF_CNT_W = 27;
    localparam int DEF_HALF  = 4999999;
    function automatic int half_for_hz(input int hz);
        return CLK_IN_HZ / (2 * hz) - 1;
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one 50%-duty divider channel with a glitch-free pending half-period update.
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_en        : channel enable; low parks the output low and clears the counter
//   i_load      : already-decoded load strobe for this channel
//   i_load_half : new half-period minus one
//   o_clk_out   : divided clock, registered
//   o_tick      : one-cycle pulse on each 0->1 edge of o_clk_out
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_half,
    output logic             o_clk_out,
    output logic             o_tick
);
    logic [CNT_W-1:0] r_cnt, r_cur, r_pend;
    logic             r_pend_v, r_clk, r_tick;
    logic             w_tc;
    assign w_tc = i_en && (r_cnt == r_cur);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_cur    <= CNT_W'(DEFAULT_HALF);
            r_pend_v <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt  <= (w_tc || !i_en) ? '0 : r_cnt + 1'b1;
            r_clk  <= i_en && (r_clk ^ w_tc);
            r_tick <= w_tc && !r_clk;
            // cur only changes when cnt restarts at 0, so cnt can never overshoot it
            if ((w_tc || !i_en) && r_pend_v) begin
                r_cur    <= r_pend;
                r_pend_v <= 1'b0;
            end
            // a load coincident with the swap above lands as the next pending value
            if (i_load) begin
                r_pend   <= i_load_half;
                r_pend_v <= 1'b1;
            end
        end
    end
    assign o_clk_out = r_clk;
    assign o_tick    = r_tick;
endmodule

// File: rtl/multi_ch_clk_divider.sv
// multi_ch_clk_divider: NUM_CH independent programmable 50%-duty clock dividers.
//   i_clk_in    : input clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_en        : per-channel enable
//   i_load      : one-cycle half-period update strobe
//   i_load_ch   : target channel of i_load (out-of-range indices are ignored)
//   i_load_half : new half-period minus one; period = 2*(H+1) cycles
//   o_load_ack  : one-cycle acknowledge of an accepted load
//   o_clk_out   : divided clocks
//   o_tick      : per-channel rising-edge pulses
module multi_ch_clk_divider
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = DEF_CNT_W,
    parameter int  DEFAULT_HALF = DEF_HALF,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk_in,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_load,
    input  logic [CH_W-1:0]   i_load_ch,
    input  logic [CNT_W-1:0]  i_load_half,
    output logic              o_load_ack,
    output logic [NUM_CH-1:0] o_clk_out,
    output logic [NUM_CH-1:0] o_tick
);
    logic w_load_ok;
    logic r_load_ack;
    // widened compare so non-power-of-two channel counts reject unused indices
    assign w_load_ok = i_load && ({1'b0, i_load_ch} < (CH_W+1)'(NUM_CH));
    always_ff @(posedge i_clk_in) begin
        r_load_ack <= !i_rst && w_load_ok;
    end
    assign o_load_ack = r_load_ack;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .i_clk       (i_clk_in),
            .i_rst       (i_rst),
            .i_en        (i_en[i]),
            .i_load      (w_load_ok && (i_load_ch == CH_W'(i))),
            .i_load_half (i_load_half),
            .o_clk_out   (o_clk_out[i]),
            .o_tick      (o_tick[i])
        );
    end
endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// tb_multi_ch_clk_divider: randomized and directed checks of the divider against a phase-length model.
module tb_multi_ch_clk_divider;
    logic       clk = 1'b0;
    logic       rst, load, load_ch, ack;
    logic [1:0] en, clk_out, tick;
    logic [7:0] load_half;
    logic [2:0] en3, clk_out3, tick3;
    logic       load3, ack3;
    logic [1:0] load_ch3;

    always #5 clk = ~clk;

    multi_ch_clk_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_HALF(4)) dut (
        .i_clk_in(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_load_ch(load_ch),
        .i_load_half(load_half), .o_load_ack(ack), .o_clk_out(clk_out), .o_tick(tick)
    );

    // three-channel instance gives room for an out-of-range channel index
    multi_ch_clk_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(4)) dut3 (
        .i_clk_in(clk), .i_rst(rst), .i_en(en3), .i_load(load3), .i_load_ch(load_ch3),
        .i_load_half(load_half), .o_load_ack(ack3), .o_clk_out(clk_out3), .o_tick(tick3)
    );

    int vecs = 0, errs = 0;
    logic [1:0] m_clk, m_tick;
    logic       m_ack;
    int         m_half[2], m_age[2], m_pend[2];
    bit         m_pv[2];
    int         last[2], ival[2], t;

    // Each enabled phase lasts half+1 cycles; a pending half-period takes effect at a phase boundary
    // or immediately while the channel is idle.
    task automatic model_step();
        if (rst) begin
            m_clk = '0; m_tick = '0; m_ack = 1'b0;
            for (int c = 0; c < 2; c++) begin m_half[c] = 4; m_age[c] = 0; m_pv[c] = 0; end
        end else begin
            m_ack = load;
            for (int c = 0; c < 2; c++) begin
                m_tick[c] = 1'b0;
                if (!en[c]) begin
                    m_clk[c] = 1'b0;
                    m_age[c] = 0;
                    if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 0; end
                end else begin
                    m_age[c]++;
                    if (m_age[c] == m_half[c] + 1) begin
                        m_clk[c]  = ~m_clk[c];
                        m_tick[c] = m_clk[c];
                        m_age[c]  = 0;
                        if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 0; end
                    end
                end
                if (load && int'(load_ch) == c) begin m_pend[c] = int'(load_half); m_pv[c] = 1; end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        t++;
    endtask

    task automatic clr_ival();
        for (int c = 0; c < 2; c++) begin last[c] = -1; ival[c] = 0; end
    endtask

    task automatic test_reset();
        rst = 1; en = 2'b11; load = 1; load_ch = 0; load_half = 8'd3; en3 = 3'b111; load3 = 0; load_ch3 = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack, clk_out3, tick3, ack3} !== 13'd0) begin
                errs++;
                $display("FAIL reset_outputs got clk=%b tick=%b ack=%b clk3=%b tick3=%b ack3=%b want all 0",
                         clk_out, tick, ack, clk_out3, tick3, ack3);
            end
        end
        load = 0;
    endtask

    task automatic test_default();
        int first = 0, n0 = 0, n1 = 0, hi = 0;
        rst = 0; en = 2'b11; en3 = 3'b111;
        for (int k = 1; k <= 30; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL default k=%0d got clk=%b tick=%b ack=%b want clk=%b tick=%b ack=%b",
                         k, clk_out, tick, ack, m_clk, m_tick, m_ack);
            end
            if (tick[0] === 1'b1 && first == 0) first = k;
            n0 += int'(tick[0]); n1 += int'(tick[1]); hi += int'(clk_out[0]);
        end
        vecs++;
        if (first != 5 || n0 != 3 || n1 != 3 || hi != 15) begin
            errs++;
            $display("FAIL default_shape got first=%0d ticks0=%0d ticks1=%0d high=%0d want 5 3 3 15", first, n0, n1, hi);
        end
    endtask

    task automatic test_load_ch0();
        repeat (2) step();
        load = 1; load_ch = 0; load_half = 8'd1;
        step();
        load = 0;
        vecs++;
        if (ack !== 1'b1) begin errs++; $display("FAIL load_ack got %b want 1", ack); end
        clr_ival();
        for (int k = 0; k < 40; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL load_ch0 k=%0d got clk=%b tick=%b ack=%b want clk=%b tick=%b ack=%b",
                         k, clk_out, tick, ack, m_clk, m_tick, m_ack);
            end
            for (int c = 0; c < 2; c++) if (tick[c] === 1'b1) begin
                if (last[c] >= 0) ival[c] = t - last[c];
                last[c] = t;
            end
        end
        vecs++;
        if (ival[0] != 4 || ival[1] != 10) begin
            errs++; $display("FAIL load_ch0_period got p0=%0d p1=%0d want 4 10", ival[0], ival[1]);
        end
    endtask

    task automatic test_double_load();
        load = 1; load_ch = 1; load_half = 8'd2;
        step();
        load_half = 8'd7;
        step();
        load = 0;
        clr_ival();
        for (int k = 0; k < 70; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL double_load k=%0d got clk=%b tick=%b ack=%b want clk=%b tick=%b ack=%b",
                         k, clk_out, tick, ack, m_clk, m_tick, m_ack);
            end
            for (int c = 0; c < 2; c++) if (tick[c] === 1'b1) begin
                if (last[c] >= 0) ival[c] = t - last[c];
                last[c] = t;
            end
        end
        vecs++;
        if (ival[0] != 4 || ival[1] != 16) begin
            errs++; $display("FAIL double_load_period got p0=%0d p1=%0d want 4 16", ival[0], ival[1]);
        end
    endtask

    task automatic test_bad_ch();
        int acks = 0, l0 = -1, l2 = -1, p0 = 0, p2 = 0;
        load3 = 1; load_ch3 = 2'd3; load_half = 8'd0;
        step();
        load3 = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL bad_ch k=%0d got clk=%b tick=%b ack=%b want clk=%b tick=%b ack=%b",
                         k, clk_out, tick, ack, m_clk, m_tick, m_ack);
            end
            acks += int'(ack3);
            if (tick3[0] === 1'b1) begin if (l0 >= 0) p0 = t - l0; l0 = t; end
            if (tick3[2] === 1'b1) begin if (l2 >= 0) p2 = t - l2; l2 = t; end
        end
        vecs++;
        if (acks != 0 || p0 != 10 || p2 != 10) begin
            errs++; $display("FAIL bad_ch_ignored got acks=%0d p0=%0d p2=%0d want 0 10 10", acks, p0, p2);
        end
    endtask

    task automatic test_disable_reload();
        bit found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL disable_sync k=%0d got clk=%b tick=%b want clk=%b tick=%b", k, clk_out, tick, m_clk, m_tick);
            end
            found = (clk_out[0] === 1'b1);
        end
        vecs++;
        if (!found) begin errs++; $display("FAIL disable_wait got timeout want clk_out0 high"); end
        en = 2'b10; load = 1; load_ch = 0; load_half = 8'd0;
        step();
        load = 0;
        vecs++;
        if (clk_out[0] !== 1'b0) begin errs++; $display("FAIL disable_low got %b want 0", clk_out[0]); end
        repeat (3) step();
        en = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step();
            vecs++;
            if ({clk_out[0], tick[0]} !== {k[0], k[0]} || {clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL reenable_h0 k=%0d got clk=%b tick=%b want clk=%b tick=%b", k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        load = 1; load_ch = 1; load_half = 8'd9;
        step();
        load = 0;
        repeat (3) step();
        rst = 1;
        step();
        vecs++;
        if ({clk_out, tick, ack} !== 5'd0) begin
            errs++; $display("FAIL reset_mid got clk=%b tick=%b ack=%b want 0", clk_out, tick, ack);
        end
        rst = 0;
        clr_ival();
        for (int k = 1; k <= 30; k++) begin
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL after_reset k=%0d got clk=%b tick=%b want clk=%b tick=%b", k, clk_out, tick, m_clk, m_tick);
            end
            for (int c = 0; c < 2; c++) if (tick[c] === 1'b1) begin
                if (last[c] >= 0) ival[c] = t - last[c];
                last[c] = t;
            end
        end
        vecs++;
        if (ival[0] != 10 || ival[1] != 10) begin
            errs++; $display("FAIL reset_discard got p0=%0d p1=%0d want 10 10", ival[0], ival[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en[0]     = ($urandom_range(0, 9) != 0);
            en[1]     = ($urandom_range(0, 9) != 0);
            load      = ($urandom_range(0, 5) == 0);
            load_ch   = 1'($urandom);
            load_half = 8'($urandom_range(0, 6));
            step();
            vecs++;
            if ({clk_out, tick, ack} !== {m_clk, m_tick, m_ack}) begin
                errs++;
                $display("FAIL random k=%0d got clk=%b tick=%b ack=%b want clk=%b tick=%b ack=%b",
                         k, clk_out, tick, ack, m_clk, m_tick, m_ack);
            end
        end
        rst = 0; load = 0;
    endtask

    initial begin
        t = 0;
        test_reset();
        test_default();
        test_load_ch0();
        test_double_load();
        test_bad_ch();
        test_disable_reload();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
